// File: rtl/data_memory_mmio.sv
// Data memory with MMIO: 256-word RAM, 4-deep TX byte FIFO, STATUS and free-running CYCLE register.
// Optional alignment checking is enabled with the DMEM_ALIGN_CHECK_EN macro.
module data_memory_mmio (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] data_mem_out,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        err_misalign
);

  // Word addresses (addr[31:2]) of the MMIO registers.
  localparam logic [29:0] TXDATA_W = 30'h3FFF_C000;
  localparam logic [29:0] STATUS_W = 30'h3FFF_C001;
  localparam logic [29:0] CYCLE_W  = 30'h3FFF_C002;

  logic [31:0] r_ram [256];
  logic [7:0]  r_fifo [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_overflow;
  logic [31:0] r_cycle;

  logic        w_misalign;
  logic        w_ok;
  logic        w_sel_ram;
  logic        w_sel_tx;
  logic        w_sel_st;
  logic        w_sel_cy;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic [31:0] w_status;

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;

  assign w_misalign = (addr[1:0] != 2'b00) & (mem_read | mem_write);

  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_misalign)
      r_err <= 1'b1;
  end

  assign err_misalign = r_err;
`else
  logic w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^addr[1:0];
  assign w_misalign        = 1'b0;
  assign err_misalign      = 1'b0;
`endif

  assign w_ok      = ~w_misalign;
  assign w_sel_ram = (addr[31:10] == 22'd0);
  assign w_sel_tx  = (addr[31:2] == TXDATA_W);
  assign w_sel_st  = (addr[31:2] == STATUS_W);
  assign w_sel_cy  = (addr[31:2] == CYCLE_W);

  assign w_empty    = (r_count == 3'd0);
  assign w_full     = (r_count == 3'd4);
  assign out_valid  = ~w_empty;
  assign out_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign w_pop      = out_valid & out_ready;
  assign w_push_req = mem_write & w_ok & w_sel_tx;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_status   = {26'd0, r_overflow, w_empty, w_full, r_count};

  always_comb begin
    data_mem_out = 32'd0;
    if (mem_read & w_ok) begin
      if (w_sel_ram)     data_mem_out = r_ram[addr[9:2]];
      else if (w_sel_st) data_mem_out = w_status;
      else if (w_sel_cy) data_mem_out = r_cycle;
    end
  end

  // RAM contents survive reset; only the write is blocked while rst is low.
  always_ff @(posedge clk) begin
    if (rst && mem_write && w_ok && w_sel_ram)
      r_ram[addr[9:2]] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst && w_push)
      r_fifo[r_wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
      r_cycle    <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push)
        r_overflow <= 1'b1;
      else if (mem_write && w_ok && w_sel_st)
        r_overflow <= 1'b0;
      if (mem_write && w_ok && w_sel_cy)
        r_cycle <= write_data;
      else
        r_cycle <= r_cycle + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio: directed scenarios then randomized traffic
// compared against a queue/array reference model.
module tb_data_memory_mmio;

  localparam logic [31:0] A_TX = 32'hFFFF_0000;
  localparam logic [31:0] A_ST = 32'hFFFF_0004;
  localparam logic [31:0] A_CY = 32'hFFFF_0008;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, out_ready;
  logic [31:0] addr, write_data;
  logic [31:0] data_mem_out;
  logic        out_valid, err_misalign;
  logic [7:0]  out_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_ram [256];
  bit          m_known [256];
  logic [7:0]  m_q [$];
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_cyc = 32'd0;

  logic [31:0] last_rd;
  logic        last_ov;
  logic [7:0]  last_od;

  always #5 clk = ~clk;

  data_memory_mmio dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .data_mem_out(data_mem_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_misalign(err_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {known, value} for a load seen before the clock edge.
  function automatic logic [32:0] m_read(input logic rd, input logic [31:0] a);
    logic [31:0] w;
    int n;
    w = {a[31:2], 2'b00};
    n = m_q.size();
    if (!rd || (ALIGN && a[1:0] != 2'b00)) return {1'b1, 32'd0};
    if (w < 32'h400) return {m_known[w[9:2]], m_ram[w[9:2]]};
    if (w == A_ST) return {1'b1, 26'd0, m_ovf, n == 0, n == 4, 3'(n)};
    if (w == A_CY) return {1'b1, m_cyc};
    return {1'b1, 32'd0};
  endfunction

  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic rdy, input logic rs);
    logic [32:0] r;
    logic [31:0] w, cyc_next;
    bit mis, pop, push;
    @(negedge clk);
    rst = rs; mem_read = rd; mem_write = wr; addr = a; write_data = wd; out_ready = rdy;
    #1;
    r = m_read(rd, a);
    if (r[32]) chk("rdata", data_mem_out, r[31:0]);
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("out_data", 32'(out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("err_misalign", 32'(err_misalign), 32'(m_err));
    last_rd = data_mem_out; last_ov = out_valid; last_od = out_data;
    @(posedge clk);
    if (!rs) begin
      m_q.delete(); m_ovf = 0; m_cyc = 0; m_err = 0;
    end else begin
      mis = ALIGN && (a[1:0] != 2'b00) && (rd || wr);
      pop = (m_q.size() != 0) && rdy;
      push = 0;
      w = {a[31:2], 2'b00};
      cyc_next = m_cyc + 32'd1;
      if (mis) m_err = 1;
      if (wr && !mis) begin
        if (w < 32'h400) begin m_ram[w[9:2]] = wd; m_known[w[9:2]] = 1; end
        else if (w == A_TX) begin
          if (m_q.size() < 4 || pop) push = 1; else m_ovf = 1;
        end
        else if (w == A_ST) m_ovf = 0;
        else if (w == A_CY) cyc_next = wd;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(wd[7:0]);
      m_cyc = cyc_next;
    end
  endtask

  initial begin
    logic [31:0] a;
    rst = 0; mem_read = 0; mem_write = 0; addr = 0; write_data = 0; out_ready = 0;
    repeat (2) @(posedge clk);

    step(1, 0, A_CY, 0, 0, 1); chk("reset_cycle", last_rd, 32'd0);
    chk("reset_valid", 32'(last_ov), 32'd0);
    step(1, 0, A_ST, 0, 0, 1); chk("reset_status", last_rd, 32'h10);

    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 1);
    step(1, 0, 32'h10, 0, 0, 1); chk("ram_rd", last_rd, 32'hDEAD_BEEF);
    step(1, 1, 32'h10, 32'h1, 0, 1); chk("ram_rw_old", last_rd, 32'hDEAD_BEEF);
    step(1, 0, 32'h10, 0, 0, 1); chk("ram_rw_new", last_rd, 32'h1);

    for (int i = 0; i < 5; i++) step(0, 1, A_TX, 32'h41 + i, 0, 1);
    step(1, 0, A_ST, 0, 0, 1); chk("fifo_ovf_status", last_rd, 32'h2C);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1); chk("fifo_drain", 32'(last_od), 32'h41 + i);
    end
    step(0, 0, 0, 0, 1, 1); chk("fifo_empty", 32'(last_ov), 32'd0);

    step(0, 1, A_ST, 32'hFFFF_FFFF, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, A_TX, 32'h61 + i, 0, 1);
    step(0, 1, A_TX, 32'h55, 1, 1);
    step(1, 0, A_ST, 0, 0, 1); chk("full_pushpop_status", last_rd, 32'h0C);

    step(0, 0, 0, 0, 1, 1);
    step(0, 1, A_TX, 32'h77, 1, 0);
    step(1, 0, A_CY, 0, 0, 1); chk("rst_cycle", last_rd, 32'd0);
    chk("rst_valid", 32'(last_ov), 32'd0);
    step(1, 0, A_ST, 0, 0, 1); chk("rst_status", last_rd, 32'h10);
    step(1, 0, 32'h10, 0, 0, 1); chk("rst_ram_kept", last_rd, 32'h1);

    step(0, 1, A_CY, 32'hFFFF_FFFE, 0, 1);
    step(1, 0, A_CY, 0, 0, 1); chk("cyc0", last_rd, 32'hFFFF_FFFE);
    step(1, 0, A_CY, 0, 0, 1); chk("cyc1", last_rd, 32'hFFFF_FFFF);
    step(1, 0, A_CY, 0, 0, 1); chk("cyc2", last_rd, 32'h0);

    step(0, 1, 32'h12, 32'hCAFE_0000, 0, 1);
    step(1, 0, 32'h10, 0, 0, 1);
    chk("misalign_ram", last_rd, ALIGN ? 32'h1 : 32'hCAFE_0000);
    step(0, 0, 0, 0, 0, 1); chk("misalign_err", 32'(err_misalign), 32'(ALIGN));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1); chk("misalign_err_rst", 32'(err_misalign), 32'd0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 15)) << 2;
        2:    a = A_TX;
        3:    a = A_ST;
        4:    a = A_CY;
        default: case ($urandom_range(0, 2))
          0: a = 32'h0000_0400;
          1: a = 32'h8000_0000;
          default: a = 32'hFFFF_000C;
        endcase
      endcase
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), a,
           $urandom, 1'($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
